// File: rtl/bada_accum_sequencer.sv
// Beat-by-beat accumulator: sums N_INPUT operands per beat over i_len beats.
// Optional macro BADA_TREE_PIPE_EN registers the adder-tree output.

module BADA_adder_tree #(
  parameter int N_INPUT  = 4,
  parameter int OP_WIDTH = 4
) (
  input  logic [N_INPUT*OP_WIDTH-1:0]          data,
  output logic [OP_WIDTH+$clog2(N_INPUT)-1:0] sum
);

  localparam int SW = OP_WIDTH + $clog2(N_INPUT);

  // Heap-ordered tree: leaves at N_INPUT-1 .. 2*N_INPUT-2, root at 0.
  always_comb begin
    logic [SW-1:0] node [2*N_INPUT-1];
    for (int k = 0; k < N_INPUT; k++) begin
      node[N_INPUT-1+k] = SW'(data[OP_WIDTH*k +: OP_WIDTH]);
    end
    for (int i = N_INPUT-2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    sum = node[0];
  end

endmodule

module bada_accum_sequencer #(
  parameter int N_INPUT   = 4,
  parameter int OP_WIDTH  = 4,
  parameter int LEN_WIDTH = 8,
  localparam int ACC_WIDTH =
    OP_WIDTH + $clog2(N_INPUT) + LEN_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [LEN_WIDTH-1:0]          i_len,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [N_INPUT*OP_WIDTH-1:0]   i_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [ACC_WIDTH-1:0]          o_data,
  output logic                          o_busy
);

  localparam int SUM_WIDTH = OP_WIDTH + $clog2(N_INPUT);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   cnt;
  logic [SUM_WIDTH-1:0]   tree_sum;
  logic                   accept;
  logic                   last;

`ifdef BADA_TREE_PIPE_EN
  logic [SUM_WIDTH-1:0]   pipe_sum;
  logic                   pipe_vld;
`endif

  BADA_adder_tree #(
    .N_INPUT  (N_INPUT),
    .OP_WIDTH (OP_WIDTH)
  ) u_tree (
    .data (i_data),
    .sum  (tree_sum)
  );

  assign accept = i_valid && o_ready;
  assign last   = (cnt == len_q - LEN_WIDTH'(1));
  assign o_data = acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      len_q   <= '0;
      cnt     <= '0;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
`ifdef BADA_TREE_PIPE_EN
      pipe_sum <= '0;
      pipe_vld <= 1'b0;
`endif
    end else begin
`ifdef BADA_TREE_PIPE_EN
      // Staged sum lands one edge after its beat was accepted.
      pipe_vld <= accept;
      if (accept) pipe_sum <= tree_sum;
      if (pipe_vld) acc <= acc + ACC_WIDTH'(pipe_sum);
`endif
      unique case (state)
        IDLE: begin
          if (i_start) begin
            acc    <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            if (i_len != '0) begin
              len_q   <= i_len;
              o_ready <= 1'b1;
              state   <= LOAD;
            end else begin
              o_valid <= 1'b1;
              state   <= DONE;
            end
          end
        end
        LOAD: begin
          if (accept) begin
`ifndef BADA_TREE_PIPE_EN
            acc <= acc + ACC_WIDTH'(tree_sum);
`endif
            cnt <= cnt + LEN_WIDTH'(1);
            if (last) begin
              o_ready <= 1'b0;
`ifdef BADA_TREE_PIPE_EN
              state   <= DRAIN;
`else
              o_valid <= 1'b1;
              state   <= DONE;
`endif
            end
          end
        end
        DRAIN: begin
          o_valid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bada_accum_sequencer.sv
// Directed job table plus a mid-job reset sequence for bada_accum_sequencer.
// Latency expectation follows BADA_TREE_PIPE_EN.

module tb_bada_accum_sequencer;

  localparam int N_INPUT   = 4;
  localparam int OP_WIDTH  = 4;
  localparam int LEN_WIDTH = 8;
  localparam int ACC_WIDTH = 14;
  localparam int DW        = N_INPUT * OP_WIDTH;

`ifdef BADA_TREE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_start;
  logic [LEN_WIDTH-1:0] i_len;
  logic                 i_valid;
  logic                 o_ready;
  logic [DW-1:0]        i_data;
  logic                 o_valid;
  logic                 i_ready;
  logic [ACC_WIDTH-1:0] o_data;
  logic                 o_busy;

  int tests = 0;
  int fails = 0;

  bada_accum_sequencer #(
    .N_INPUT   (N_INPUT),
    .OP_WIDTH  (OP_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_len   (i_len),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int            len;
    logic [DW-1:0] data;
    int            gap;
    int            hold;
    int            exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_job(input vec_t v);
    int cyc;
    check("idle_busy", int'(o_busy), 0);
    check("idle_ready", int'(o_ready), 0);
    i_start = 1'b1;
    i_len   = LEN_WIDTH'(v.len);
    tick();
    i_start = 1'b0;
    i_len   = '0;
    if (v.len == 0) begin
      check("len0_ready", int'(o_ready), 0);
      check("len0_valid", int'(o_valid), 1);
    end else begin
      for (int b = 0; b < v.len; b++) begin
        if (b == 0) check("load_ready", int'(o_ready), 1);
        i_valid = 1'b1;
        i_data  = v.data;
        tick();
        i_valid = 1'b0;
        i_data  = '0;
        if (b < v.len - 1) begin
          for (int g = 0; g < v.gap; g++) begin
            check("gap_ready", int'(o_ready), 1);
            tick();
          end
        end
      end
      check("last_ready", int'(o_ready), 0);
      cyc = 1;
      while (!o_valid && cyc < 8) begin
        tick();
        cyc++;
      end
      check("latency", cyc, LAT);
    end
    check("result", int'(o_data), v.exp);
    for (int h = 0; h < v.hold; h++) begin
      i_start = (h == 2);
      i_len   = (h == 2) ? LEN_WIDTH'(3) : '0;
      tick();
      check("hold_valid", int'(o_valid), 1);
      check("hold_data", int'(o_data), v.exp);
    end
    i_start = 1'b0;
    i_len   = '0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("post_valid", int'(o_valid), 0);
    check("post_busy", int'(o_busy), 0);
  endtask

  initial begin
    vecs[0] = '{len: 1,   data: 16'h1111, gap: 0, hold: 0, exp: 4};
    vecs[1] = '{len: 3,   data: 16'hFFFF, gap: 1, hold: 0, exp: 180};
    vecs[2] = '{len: 0,   data: 16'h0000, gap: 0, hold: 0, exp: 0};
    vecs[3] = '{len: 255, data: 16'hFFFF, gap: 0, hold: 5, exp: 15300};
    vecs[4] = '{len: 4,   data: 16'h1234, gap: 2, hold: 1, exp: 40};
    vecs[5] = '{len: 2,   data: 16'hF0A5, gap: 0, hold: 0, exp: 60};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_len   = '0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    repeat (3) tick();
    check("rst_ready", int'(o_ready), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_data", int'(o_data), 0);
    #3 i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // Reset in the middle of a four-beat job.
    i_start = 1'b1;
    i_len   = LEN_WIDTH'(4);
    tick();
    i_start = 1'b0;
    i_len   = '0;
    for (int b = 0; b < 2; b++) begin
      i_valid = 1'b1;
      i_data  = 16'hFFFF;
      tick();
    end
    i_valid = 1'b0;
    i_data  = '0;
    tick();
    check("mid_busy", int'(o_busy), 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_ready", int'(o_ready), 0);
    check("arst_valid", int'(o_valid), 0);
    check("arst_busy", int'(o_busy), 0);
    check("arst_data", int'(o_data), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    run_job('{len: 2, data: 16'h1111, gap: 0, hold: 0, exp: 8});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bada_accum_sequencer.md
BADA_ACCUM_SEQUENCER -- requirements
Module: bada_accum_sequencer

Interface
REQ-001 SHALL have parameter N_INPUT, default 4, meaning operands per beat (power of two, >=2).
REQ-002 SHALL have parameter OP_WIDTH, default 4, meaning unsigned operand width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, meaning beat-count field width.
REQ-004 SHALL derive local parameter ACC_WIDTH = OP_WIDTH + $clog2(N_INPUT) + LEN_WIDTH; default 14.
REQ-005 SHALL have one clock and an asynchronous active-low reset, named i_clk and i_rst_n.
REQ-006 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_start  input  1  begin a job; sampled only in IDLE.
REQ-009 i_len  input  LEN_WIDTH  number of beats in the job; sampled with i_start.
REQ-010 i_valid  input  1  operand beat valid.
REQ-011 o_ready  output  1  sequencer accepts a beat.
REQ-012 i_data  input  N_INPUT*OP_WIDTH  packed operands, operand k at bits [OP_WIDTH*(k+1)-1 : OP_WIDTH*k].
REQ-013 o_valid  output  1  result valid.
REQ-014 i_ready  input  1  result consumer ready.
REQ-015 o_data  output  ACC_WIDTH  accumulated sum.
REQ-016 o_busy  output  1  job in progress (any state except IDLE).

Function
REQ-017 SHALL instantiate BADA_adder_tree (N_INPUT, OP_WIDTH) on i_data; tree sum width is OP_WIDTH+$clog2(N_INPUT), zero-extended to ACC_WIDTH.
REQ-018 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE: i_start with i_len!=0 -> clear accumulator, latch i_len, beat counter=0, go LOAD; i_start with i_len==0 -> clear accumulator, go DONE; i_start outside IDLE ignored.
REQ-020 LOAD: o_ready=1; beat accepted on edge where i_valid&&o_ready; i_valid low cycles insert gaps without state change.
REQ-021 On acceptance of beat number len (counter==len-1) SHALL go DRAIN; o_ready low from the next cycle.
REQ-022 DRAIN: one cycle, commits the final pending sum to the accumulator, then DONE.
REQ-023 DONE: o_valid=1, o_data=accumulator, both held stable until i_valid... i.e. until i_ready sampled high; then IDLE, o_valid low next cycle.
REQ-024 Accumulator SHALL be unsigned, ACC_WIDTH bits, sized so 2^LEN_WIDTH-1 beats of all-max operands never wrap.
REQ-025 o_ready SHALL be 0 in IDLE, DRAIN, DONE; o_valid SHALL be 0 outside DONE.
REQ-026 o_data SHALL be driven from the accumulator register in all states (no combinational path from i_data).

Reset
REQ-027 Asserting i_rst_n low SHALL immediately force IDLE, o_ready=0, o_valid=0, o_busy=0, o_data=0, counter=0, pipeline valid=0, regardless of state.
REQ-028 Reset mid-job SHALL discard the job; no partial result is ever presented.
REQ-029 After deassertion, first i_start SHALL be honoured on the first rising edge.

Configuration
REQ-030 Macro BADA_TREE_PIPE_EN SHALL control a register stage on the adder-tree output.
REQ-031 With BADA_TREE_PIPE_EN defined: tree sum registered on acceptance, added to accumulator next edge; DRAIN present; o_valid rises 2 cycles after the last-beat handshake edge.
REQ-032 Without BADA_TREE_PIPE_EN: tree sum added to accumulator on the acceptance edge; DRAIN skipped (LOAD -> DONE); o_valid rises 1 cycle after the last-beat handshake edge.
REQ-033 Final o_data SHALL be identical in both configurations.

Verification
REQ-034 len=1, all four operands=1 -> o_data=4; o_valid 2 cycles after handshake with macro, 1 without.
REQ-035 len=3, all operands=15, i_valid with one idle cycle between beats -> o_data=180; o_ready low after third beat.
REQ-036 len=0 -> no o_ready assertion; DONE with o_data=0, o_valid next cycle.
REQ-037 len=255, all operands=15, continuous -> o_data=15300, no wrap; then hold i_ready=0 for 5 cycles and pulse i_start -> o_valid/o_data stable, i_start ignored, IDLE after i_ready=1.
REQ-038 i_rst_n low after 2 of 4 beats -> all outputs 0 immediately; new job len=2, operands=1 -> o_data=8.
